// File: rtl/cpx_multiply_arbiter.sv
// Round-robin arbiter sharing one cpx_multiply between NUM_REQ requesters, with tag tracking.
// Optional sticky tag-mismatch checker enabled by defining CPX_ARB_ERRCHK_EN.
module cpx_multiply_arbiter #(
    parameter int unsigned NUM_REQ      = 4,
    parameter int unsigned ID_BITS      = 2,
    parameter int unsigned DATA_BITS    = 12,
    parameter int unsigned OUT_BITS     = 25,
    parameter int unsigned MULT_LATENCY = 3
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [NUM_REQ-1:0]             req_tvalid,
    output logic [NUM_REQ-1:0]             req_tready,
    input  logic [NUM_REQ*DATA_BITS-1:0]   req_xi,
    input  logic [NUM_REQ*DATA_BITS-1:0]   req_xq,
    input  logic [NUM_REQ*DATA_BITS-1:0]   req_yi,
    input  logic [NUM_REQ*DATA_BITS-1:0]   req_yq,
    output logic                           m_axis_tready,
    output logic                           m_axis_x_tvalid,
    output logic                           m_axis_y_tvalid,
    output logic [DATA_BITS-1:0]           xi,
    output logic [DATA_BITS-1:0]           xq,
    output logic [DATA_BITS-1:0]           yi,
    output logic [DATA_BITS-1:0]           yq,
    input  logic                           s_axis_i_tvalid,
    input  logic                           s_axis_q_tvalid,
    input  logic [OUT_BITS-1:0]            i_out,
    input  logic [OUT_BITS-1:0]            q_out,
    output logic                           res_tvalid,
    output logic [ID_BITS-1:0]             res_tid,
    output logic [OUT_BITS-1:0]            res_i,
    output logic [OUT_BITS-1:0]            res_q,
    output logic                           overflow_err
);

    logic [ID_BITS-1:0]                     rr_ptr;
    logic [ID_BITS-1:0]                     winner;
    logic                                   found;
    logic                                   accept;
    int unsigned                            scan_idx;
    logic [ID_BITS-1:0]                     op_id;
    logic [MULT_LATENCY-1:0]                tag_vld;
    logic [MULT_LATENCY-1:0][ID_BITS-1:0]   tag_id;

    // First valid requester at or after rr_ptr, wrapping.
    always_comb begin
        req_tready = '0;
        winner     = '0;
        found      = 1'b0;
        scan_idx   = 0;
        if (!reset) begin
            for (int unsigned i = 0; i < NUM_REQ; i++) begin
                scan_idx = (32'(rr_ptr) + i) % NUM_REQ;
                if (!found && req_tvalid[scan_idx[ID_BITS-1:0]]) begin
                    found  = 1'b1;
                    winner = scan_idx[ID_BITS-1:0];
                end
            end
            if (found) begin
                req_tready[winner] = 1'b1;
            end
        end
    end

    assign accept = |(req_tvalid & req_tready);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            m_axis_x_tvalid <= 1'b0;
            xi              <= '0;
            xq              <= '0;
            yi              <= '0;
            yq              <= '0;
            op_id           <= '0;
            rr_ptr          <= '0;
            tag_vld         <= '0;
            tag_id          <= '0;
        end else begin
            m_axis_x_tvalid <= accept;
            op_id           <= winner;
            if (accept) begin
                xi     <= req_xi[32'(winner)*DATA_BITS +: DATA_BITS];
                xq     <= req_xq[32'(winner)*DATA_BITS +: DATA_BITS];
                yi     <= req_yi[32'(winner)*DATA_BITS +: DATA_BITS];
                yq     <= req_yq[32'(winner)*DATA_BITS +: DATA_BITS];
                rr_ptr <= ID_BITS'((32'(winner) + 1) % NUM_REQ);
            end
            // Stage 0 follows the operand register so the tail lines up with multiplier output.
            tag_vld[0] <= m_axis_x_tvalid;
            tag_id[0]  <= op_id;
            for (int unsigned j = 1; j < MULT_LATENCY; j++) begin
                tag_vld[j] <= tag_vld[j-1];
                tag_id[j]  <= tag_id[j-1];
            end
        end
    end

    assign m_axis_tready   = ~reset;
    assign m_axis_y_tvalid = m_axis_x_tvalid;

    assign res_tvalid = s_axis_i_tvalid & s_axis_q_tvalid;
    assign res_tid    = tag_id[MULT_LATENCY-1];
    assign res_i      = i_out;
    assign res_q      = q_out;

`ifdef CPX_ARB_ERRCHK_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overflow_err <= 1'b0;
        end else if (res_tvalid != tag_vld[MULT_LATENCY-1]) begin
            overflow_err <= 1'b1;
        end
    end
`else
    assign overflow_err = 1'b0;
`endif

endmodule

// File: tb/tb_cpx_multiply_arbiter.sv
// Randomized self-checking bench for cpx_multiply_arbiter with a behavioural multiplier and
// round-robin reference model.
module tb_cpx_multiply_arbiter;

    localparam int NR = 4;
    localparam int IB = 2;
    localparam int DB = 12;
    localparam int OB = 25;
    localparam int L  = 3;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic [NR-1:0]     req_tvalid = '0;
    logic [NR-1:0]     req_tready;
    logic [NR*DB-1:0]  req_xi = '0, req_xq = '0, req_yi = '0, req_yq = '0;
    logic              m_axis_tready, m_axis_x_tvalid, m_axis_y_tvalid;
    logic [DB-1:0]     xi, xq, yi, yq;
    logic              s_axis_i_tvalid, s_axis_q_tvalid;
    logic [OB-1:0]     i_out, q_out;
    logic              res_tvalid;
    logic [IB-1:0]     res_tid;
    logic [OB-1:0]     res_i, res_q;
    logic              overflow_err;

    cpx_multiply_arbiter #(
        .NUM_REQ(NR), .ID_BITS(IB), .DATA_BITS(DB), .OUT_BITS(OB), .MULT_LATENCY(L)
    ) dut (
        .clk(clk), .reset(reset),
        .req_tvalid(req_tvalid), .req_tready(req_tready),
        .req_xi(req_xi), .req_xq(req_xq), .req_yi(req_yi), .req_yq(req_yq),
        .m_axis_tready(m_axis_tready), .m_axis_x_tvalid(m_axis_x_tvalid),
        .m_axis_y_tvalid(m_axis_y_tvalid),
        .xi(xi), .xq(xq), .yi(yi), .yq(yq),
        .s_axis_i_tvalid(s_axis_i_tvalid), .s_axis_q_tvalid(s_axis_q_tvalid),
        .i_out(i_out), .q_out(q_out),
        .res_tvalid(res_tvalid), .res_tid(res_tid), .res_i(res_i), .res_q(res_q),
        .overflow_err(overflow_err)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    task automatic chk(input string nm, input logic signed [63:0] act,
                       input logic signed [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", nm, act, exp, $time);
        end
    endtask

    // Behavioural multiplier: complex product after L cycles.
    logic [L-1:0] mv;
    longint       mi[L];
    longint       mq[L];
    logic         force_res = 1'b0;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            mv <= '0;
            for (int j = 0; j < L; j++) begin
                mi[j] <= 0;
                mq[j] <= 0;
            end
        end else begin
            mv[0] <= m_axis_x_tvalid & m_axis_y_tvalid & m_axis_tready;
            mi[0] <= longint'($signed(xi)) * longint'($signed(yi))
                   - longint'($signed(xq)) * longint'($signed(yq));
            mq[0] <= longint'($signed(xi)) * longint'($signed(yq))
                   + longint'($signed(xq)) * longint'($signed(yi));
            for (int j = 1; j < L; j++) begin
                mv[j] <= mv[j-1];
                mi[j] <= mi[j-1];
                mq[j] <= mq[j-1];
            end
        end
    end

    assign s_axis_i_tvalid = mv[L-1] | force_res;
    assign s_axis_q_tvalid = mv[L-1] | force_res;
    assign i_out = OB'(mi[L-1]);
    assign q_out = OB'(mq[L-1]);

    // Reference model state.
    typedef struct {
        int     due;
        int     id;
        longint pi;
        longint pq;
    } exp_t;

    exp_t   eq[$];
    int     glog[$];
    int     pcyc = 0;
    int     mptr = 0;
    logic   prev_acc = 1'b0;
    logic   exp_err = 1'b0;
    int     nres = 0;
    int     last_tid = -1;
    longint last_pi = 0, last_pq = 0;

    always @(posedge clk) pcyc <= pcyc + 1;

    always @(posedge clk or posedge reset) begin
        if (reset) exp_err <= 1'b0;
        else if (force_res) exp_err <= 1'b1;
    end

    function automatic longint sx(input logic [NR*DB-1:0] v, input int r);
        logic [DB-1:0] s;
        s = v[r*DB +: DB];
        return longint'($signed(s));
    endfunction

    always @(negedge clk) begin
        int   w;
        int   idx;
        exp_t e;
        if (reset) begin
            eq.delete();
            mptr     = 0;
            prev_acc = 1'b0;
            chk("rdy_in_reset", req_tready, 0);
            chk("mtready_in_reset", m_axis_tready, 0);
            chk("mval_in_reset", m_axis_x_tvalid, 0);
            chk("res_in_reset", res_tvalid, 0);
            chk("err_in_reset", overflow_err, 0);
        end else begin
            chk("mtready", m_axis_tready, 1);
            chk("mxval", m_axis_x_tvalid, prev_acc);
            chk("myval", m_axis_y_tvalid, prev_acc);
            if (!force_res) begin
                if (eq.size() > 0 && eq[0].due == pcyc) begin
                    e = eq.pop_front();
                    chk("res_valid", res_tvalid, 1);
                    chk("res_tid", res_tid, e.id);
                    chk("res_i", $signed(res_i), e.pi);
                    chk("res_q", $signed(res_q), e.pq);
                    nres++;
                    last_tid = e.id;
                    last_pi  = e.pi;
                    last_pq  = e.pq;
                end else begin
                    chk("res_idle", res_tvalid, 0);
                end
            end
            chk("overflow_err", overflow_err, exp_err);
            w = -1;
            for (int i = 0; i < NR; i++) begin
                idx = (mptr + i) % NR;
                if (w < 0 && req_tvalid[idx]) w = idx;
            end
            chk("req_tready", req_tready, (w >= 0) ? (1 << w) : 0);
            prev_acc = (w >= 0);
            if (w >= 0) begin
                e.due = pcyc + 1 + L;
                e.id  = w;
                e.pi  = sx(req_xi, w) * sx(req_yi, w) - sx(req_xq, w) * sx(req_yq, w);
                e.pq  = sx(req_xi, w) * sx(req_yq, w) + sx(req_xq, w) * sx(req_yi, w);
                eq.push_back(e);
                glog.push_back(w);
                mptr = (w + 1) % NR;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int r, input int a, input int b, input int c, input int d);
        req_xi[r*DB +: DB] = DB'(a);
        req_xq[r*DB +: DB] = DB'(b);
        req_yi[r*DB +: DB] = DB'(c);
        req_yq[r*DB +: DB] = DB'(d);
    endtask

    task automatic rand_data();
        for (int r = 0; r < NR; r++) begin
            set_req(r, int'($urandom), int'($urandom), int'($urandom), int'($urandom));
        end
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic chk_log(input string nm, input int exp_seq[8], input int n);
        chk({nm, "_len"}, glog.size(), n);
        for (int i = 0; i < n; i++) begin
            chk(nm, (i < glog.size()) ? glog[i] : -1, exp_seq[i]);
        end
    endtask

    initial begin
        int rr_seq[8];
        int two_seq[8];
        int n0;
        rr_seq  = '{0, 1, 2, 3, 0, 1, 2, 3};
        two_seq = '{1, 3, 1, 3, 0, 0, 0, 0};

        repeat (3) tick();
        reset = 1'b0;
        #1;
        chk("mtready_after_release", m_axis_tready, 1);
        repeat (3) tick();

        // Lone requester 2 for 5 cycles.
        glog.delete();
        n0 = nres;
        set_req(2, 3, 4, 1, -2);
        req_tvalid = 4'b0100;
        repeat (5) tick();
        req_tvalid = '0;
        repeat (8) tick();
        chk("lone_grants", glog.size(), 5);
        chk("lone_results", nres - n0, 5);
        chk("lone_tid", last_tid, 2);
        chk("lone_i", last_pi, 11);
        chk("lone_q", last_pq, -2);

        // All four valid from rr_ptr=0.
        apply_reset();
        glog.delete();
        rand_data();
        req_tvalid = 4'b1111;
        repeat (8) tick();
        req_tvalid = '0;
        repeat (6) tick();
        chk_log("rr_all", rr_seq, 8);

        // Requesters 1 and 3 after last grant 3.
        glog.delete();
        rand_data();
        req_tvalid = 4'b1010;
        repeat (4) tick();
        req_tvalid = '0;
        repeat (6) tick();
        chk_log("rr_two", two_seq, 4);

        // Reset with three products in flight.
        rand_data();
        req_tvalid = 4'b1111;
        repeat (3) tick();
        req_tvalid = '0;
        reset = 1'b1;
        #1;
        chk("rst_mid_res", res_tvalid, 0);
        chk("rst_mid_mval", m_axis_x_tvalid, 0);
        tick();
        tick();
        reset = 1'b0;
        glog.delete();
        req_tvalid = 4'b1111;
        tick();
        req_tvalid = '0;
        repeat (6) tick();
        chk("post_rst_first", (glog.size() > 0) ? glog[0] : -1, 0);

        // Randomized traffic.
        for (int c = 0; c < 400; c++) begin
            rand_data();
            req_tvalid = NR'($urandom);
            tick();
        end
        req_tvalid = '0;
        repeat (8) tick();
        chk("rand_drained", eq.size(), 0);

`ifdef CPX_ARB_ERRCHK_EN
        force_res = 1'b1;
        tick();
        force_res = 1'b0;
        chk("err_set", overflow_err, 1);
        repeat (3) tick();
        chk("err_sticky", overflow_err, 1);
        apply_reset();
        #1;
        chk("err_cleared", overflow_err, 0);
        repeat (2) tick();
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
